// File: rtl/regfile_pkg.sv
// Shared constants for the register bank write scheduler and its scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned REG_BITS     = 5;
    localparam int unsigned NUM_REGS     = 2 ** REG_BITS;
    localparam int unsigned STARVE_LIMIT = 4;

    localparam logic [REG_BITS-1:0] ZERO_REG = '0;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Write-port, MDU, decode and scoreboard signals between pipeline and scheduler.
interface regfile_write_scheduler_if #(
    parameter int unsigned DATA_WIDTH = regfile_pkg::DATA_WIDTH,
    parameter int unsigned REG_BITS   = regfile_pkg::REG_BITS
);
    logic                      wb_valid;
    logic [REG_BITS-1:0]       wb_reg;
    logic [DATA_WIDTH-1:0]     wb_data;

    logic                      mdu_valid;
    logic [REG_BITS-1:0]       mdu_reg;
    logic [DATA_WIDTH-1:0]     mdu_data;
    logic                      mdu_ready;

    logic                      iss_valid;
    logic [REG_BITS-1:0]       iss_reg;
    logic [REG_BITS-1:0]       dec_rs;
    logic [REG_BITS-1:0]       dec_rt;
    logic [REG_BITS-1:0]       dec_rd;
    logic                      dec_stall;
    logic                      hold_pipeline;

    logic                      sinal_escrita;
    logic [REG_BITS-1:0]       reg_escrita;
    logic [DATA_WIDTH-1:0]     dado_escrita;
    logic [(2**REG_BITS)-1:0]  busy_vec;

    modport master (
        output wb_valid, wb_reg, wb_data,
        output mdu_valid, mdu_reg, mdu_data,
        input  mdu_ready,
        output iss_valid, iss_reg, dec_rs, dec_rt, dec_rd,
        input  dec_stall, hold_pipeline,
        input  sinal_escrita, reg_escrita, dado_escrita, busy_vec
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  mdu_valid, mdu_reg, mdu_data,
        output mdu_ready,
        input  iss_valid, iss_reg, dec_rs, dec_rt, dec_rd,
        output dec_stall, hold_pipeline,
        output sinal_escrita, reg_escrita, dado_escrita, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bit per register for pending MDU results, with three decode hazard lookups.
module regfile_scoreboard #(
    parameter int unsigned REG_BITS = regfile_pkg::REG_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      set_en,
    input  logic [REG_BITS-1:0]       set_idx,
    input  logic                      clr_en,
    input  logic [REG_BITS-1:0]       clr_idx,
    input  logic [REG_BITS-1:0]       rs_idx,
    input  logic [REG_BITS-1:0]       rt_idx,
    input  logic [REG_BITS-1:0]       rd_idx,
    output logic                      rs_busy_c,
    output logic                      rt_busy_c,
    output logic                      rd_busy_c,
    output logic [(2**REG_BITS)-1:0]  busy_vec
);
    import regfile_pkg::*;

    logic [(2**REG_BITS)-1:0] busy_next;

    // Clear first so a same-index set on the same edge wins; r0 is pinned idle.
    always_comb begin
        busy_next = busy_vec;
        if (clr_en) busy_next[clr_idx] = 1'b0;
        if (set_en) busy_next[set_idx] = 1'b1;
        busy_next[REG_BITS'(ZERO_REG)] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) busy_vec <= '0;
        else       busy_vec <= busy_next;
    end

    assign rs_busy_c = (rs_idx != REG_BITS'(ZERO_REG)) && busy_vec[rs_idx];
    assign rt_busy_c = (rt_idx != REG_BITS'(ZERO_REG)) && busy_vec[rt_idx];
    assign rd_busy_c = (rd_idx != REG_BITS'(ZERO_REG)) && busy_vec[rd_idx];

endmodule

// File: rtl/regfile_write_scheduler.sv
// Shares the register bank write port between pipeline writeback and a buffered
// MDU result; tracks pending MDU destinations and holds the pipeline on starvation.
module regfile_write_scheduler #(
    parameter int unsigned DATA_WIDTH   = regfile_pkg::DATA_WIDTH,
    parameter int unsigned REG_BITS     = regfile_pkg::REG_BITS,
    parameter int unsigned STARVE_LIMIT = regfile_pkg::STARVE_LIMIT
) (
    input  logic                      clock,
    input  logic                      reset,
    regfile_write_scheduler_if.slave  bus
);
    import regfile_pkg::*;

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    buf_state_t               buf_state, buf_state_next;
    logic [REG_BITS-1:0]      buf_reg, buf_reg_next;
    logic [DATA_WIDTH-1:0]    buf_data, buf_data_next;
    logic [CNT_W-1:0]         starve_cnt, starve_cnt_next;
    logic                     hold_next;

    logic                     buf_full;
    logic                     drain;
    logic                     take;
    logic                     iss_busy;
    logic                     haz_rs, haz_rt, haz_rd;
    logic                     sb_set, sb_clr;
    logic [(2**REG_BITS)-1:0] busy_vec;

    // The buffer drains whenever the pipeline leaves the port free.
    assign buf_full      = (buf_state == BUF_FULL);
    assign drain         = buf_full && !bus.wb_valid;
    assign bus.mdu_ready = !buf_full || drain;
    assign take          = bus.mdu_valid && bus.mdu_ready;

    assign iss_busy      = bus.iss_valid && busy_vec[bus.iss_reg];
    assign bus.dec_stall = haz_rs || haz_rt || haz_rd || iss_busy;
    assign sb_set        = bus.iss_valid && !bus.dec_stall && (bus.iss_reg != REG_BITS'(ZERO_REG));
    assign sb_clr        = drain && (buf_reg != REG_BITS'(ZERO_REG));
    assign bus.busy_vec  = busy_vec;

    regfile_scoreboard #(.REG_BITS(REG_BITS)) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (sb_set),
        .set_idx   (bus.iss_reg),
        .clr_en    (sb_clr),
        .clr_idx   (buf_reg),
        .rs_idx    (bus.dec_rs),
        .rt_idx    (bus.dec_rt),
        .rd_idx    (bus.dec_rd),
        .rs_busy_c (haz_rs),
        .rt_busy_c (haz_rt),
        .rd_busy_c (haz_rd),
        .busy_vec  (busy_vec)
    );

    // Write port mux: pipeline first, then the buffered MDU result.
    always_comb begin
        bus.sinal_escrita = 1'b0;
        bus.reg_escrita   = '0;
        bus.dado_escrita  = '0;
        if (bus.wb_valid) begin
            bus.sinal_escrita = 1'b1;
            bus.reg_escrita   = bus.wb_reg;
            bus.dado_escrita  = bus.wb_data;
        end else if (buf_full) begin
            bus.sinal_escrita = 1'b1;
            bus.reg_escrita   = buf_reg;
            bus.dado_escrita  = buf_data;
        end
    end

    // Buffer occupancy and starvation counter next-state.
    always_comb begin
        buf_state_next  = buf_state;
        buf_reg_next    = buf_reg;
        buf_data_next   = buf_data;
        starve_cnt_next = '0;
        hold_next       = 1'b0;
        case (buf_state)
            BUF_EMPTY: begin
                if (take) begin
                    buf_state_next = BUF_FULL;
                    buf_reg_next   = bus.mdu_reg;
                    buf_data_next  = bus.mdu_data;
                end
            end
            BUF_FULL: begin
                if (drain) begin
                    if (take) begin
                        buf_reg_next  = bus.mdu_reg;
                        buf_data_next = bus.mdu_data;
                    end else begin
                        buf_state_next = BUF_EMPTY;
                    end
                end else begin
                    starve_cnt_next = (starve_cnt < CNT_W'(STARVE_LIMIT)) ?
                                      starve_cnt + CNT_W'(1) : starve_cnt;
                    hold_next       = (starve_cnt_next >= CNT_W'(STARVE_LIMIT));
                end
            end
            default: buf_state_next = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_state         <= BUF_EMPTY;
            buf_reg           <= '0;
            buf_data          <= '0;
            starve_cnt        <= '0;
            bus.hold_pipeline <= 1'b0;
        end else begin
            buf_state         <= buf_state_next;
            buf_reg           <= buf_reg_next;
            buf_data          <= buf_data_next;
            starve_cnt        <= starve_cnt_next;
            bus.hold_pipeline <= hold_next;
        end
    end

    // Protocol violations by the surrounding pipeline or MDU.
    a_wb_not_busy: assert property (@(posedge clock) disable iff (reset)
        bus.wb_valid |-> !busy_vec[bus.wb_reg]);
    a_mdu_was_issued: assert property (@(posedge clock) disable iff (reset)
        take |-> busy_vec[bus.mdu_reg]);
    a_hold_honoured: assert property (@(posedge clock) disable iff (reset)
        bus.hold_pipeline |-> !bus.wb_valid);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench: expected bank writes are queued at stimulus time and checked by a monitor.
module tb_regfile_write_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [36:0] exp_q[$];
    logic [36:0] exp_w;

    always #5 clock = ~clock;

    regfile_write_scheduler_if #(.DATA_WIDTH(32), .REG_BITS(5)) bus ();

    regfile_write_scheduler #(.DATA_WIDTH(32), .REG_BITS(5), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clock);
    endtask

    task automatic idle();
        bus.wb_valid  = 1'b0; bus.wb_reg  = '0; bus.wb_data  = '0;
        bus.mdu_valid = 1'b0; bus.mdu_reg = '0; bus.mdu_data = '0;
        bus.iss_valid = 1'b0; bus.iss_reg = '0;
        bus.dec_rs = '0; bus.dec_rt = '0; bus.dec_rd = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
        exp_q.push_back({r, d});
    endtask

    // Every bank write seen outside reset must match the head of the queue.
    always @(negedge clock) begin
        if (reset === 1'b0 && bus.sinal_escrita !== 1'b0) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got r%0d=%0h, required no write",
                         bus.reg_escrita, bus.dado_escrita);
            end else begin
                exp_w = exp_q.pop_front();
                if ({bus.reg_escrita, bus.dado_escrita} !== exp_w) begin
                    bad++;
                    $display("FAIL bank_write: got r%0d=%0h, required r%0d=%0h",
                             bus.reg_escrita, bus.dado_escrita, exp_w[36:32], exp_w[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        // Reset
        reset = 1'b1;
        tick(); tick();
        at_neg();
        chk("rst_busy",  64'(bus.busy_vec), 64'h0);
        chk("rst_ready", 64'(bus.mdu_ready), 64'h1);
        chk("rst_we",    64'(bus.sinal_escrita), 64'h0);
        chk("rst_hold",  64'(bus.hold_pipeline), 64'h0);
        chk("rst_stall", 64'(bus.dec_stall), 64'h0);
        tick(); reset = 1'b0;

        // Issue r5 and retire it through the buffer
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd5;
        at_neg(); chk("iss5_no_stall", 64'(bus.dec_stall), 64'h0);
        tick(); idle(); bus.dec_rs = 5'd5;
        at_neg();
        chk("busy5_set",  64'(bus.busy_vec), 64'h20);
        chk("raw_rs5",    64'(bus.dec_stall), 64'h1);
        tick(); idle();
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd5; bus.mdu_data = 32'hDEADBEEF;
        push_wr(5'd5, 32'hDEADBEEF);
        at_neg();
        chk("mdu5_ready",      64'(bus.mdu_ready), 64'h1);
        chk("mdu5_not_direct", 64'(bus.sinal_escrita), 64'h0);
        tick(); idle();
        at_neg(); chk("busy5_during_write", 64'(bus.busy_vec), 64'h20);
        tick();
        at_neg(); chk("busy5_cleared", 64'(bus.busy_vec), 64'h0);

        // Port conflict: buffered r7 waits behind pipeline writes to r3
        tick(); bus.iss_valid = 1'b1; bus.iss_reg = 5'd7;
        tick(); idle();
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd7; bus.mdu_data = 32'h77;
        bus.wb_valid  = 1'b1; bus.wb_reg  = 5'd3; bus.wb_data  = 32'h11;
        push_wr(5'd3, 32'h11); push_wr(5'd3, 32'h22); push_wr(5'd7, 32'h77);
        at_neg(); chk("conflict_port_reg", 64'(bus.reg_escrita), 64'h3);
        tick(); idle();
        bus.wb_valid = 1'b1; bus.wb_reg = 5'd3; bus.wb_data = 32'h22;
        at_neg(); chk("conflict_full_not_ready", 64'(bus.mdu_ready), 64'h0);
        tick(); idle();
        at_neg(); chk("conflict_drain_ready", 64'(bus.mdu_ready), 64'h1);
        tick();
        at_neg(); chk("conflict_busy_clear", 64'(bus.busy_vec), 64'h0);

        // Starvation: r9 buffered while the pipeline writes r1 every cycle
        tick(); bus.iss_valid = 1'b1; bus.iss_reg = 5'd9;
        tick(); idle();
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd9; bus.mdu_data = 32'h99;
        for (int i = 0; i < 5; i++) begin
            bus.wb_valid = 1'b1; bus.wb_reg = 5'd1; bus.wb_data = 32'h100 + 32'(i);
            push_wr(5'd1, 32'h100 + 32'(i));
            if (i == 1) bus.dec_rd = 5'd9;
            if (i == 2) bus.dec_rt = 5'd9;
            at_neg();
            chk($sformatf("starve_hold_low_%0d", i), 64'(bus.hold_pipeline), 64'h0);
            if (i == 1) chk("waw_rd9", 64'(bus.dec_stall), 64'h1);
            if (i == 2) chk("raw_rt9", 64'(bus.dec_stall), 64'h1);
            tick(); idle();
        end
        push_wr(5'd9, 32'h99);
        at_neg(); chk("starve_hold_high", 64'(bus.hold_pipeline), 64'h1);
        tick();
        at_neg();
        chk("starve_hold_drop", 64'(bus.hold_pipeline), 64'h0);
        chk("starve_busy_clear", 64'(bus.busy_vec), 64'h0);

        // Back-to-back MDU results r4 then r6
        tick(); bus.iss_valid = 1'b1; bus.iss_reg = 5'd4;
        tick(); bus.iss_reg = 5'd6;
        tick(); idle();
        at_neg(); chk("b2b_busy", 64'(bus.busy_vec), 64'h50);
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd4; bus.mdu_data = 32'h44;
        push_wr(5'd4, 32'h44);
        tick(); idle();
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd6; bus.mdu_data = 32'h66;
        push_wr(5'd6, 32'h66);
        at_neg(); chk("b2b_ready_refill", 64'(bus.mdu_ready), 64'h1);
        tick(); idle();
        at_neg(); chk("b2b_ready_drain", 64'(bus.mdu_ready), 64'h1);
        tick();
        at_neg(); chk("b2b_busy_clear", 64'(bus.busy_vec), 64'h0);

        // Zero register and WAW on issue
        tick(); bus.iss_valid = 1'b1; bus.iss_reg = 5'd0;
        at_neg(); chk("iss0_no_stall", 64'(bus.dec_stall), 64'h0);
        tick(); idle();
        at_neg(); chk("iss0_not_busy", 64'(bus.busy_vec), 64'h0);
        bus.iss_valid = 1'b1; bus.iss_reg = 5'd5;
        tick(); bus.iss_valid = 1'b1; bus.iss_reg = 5'd5;
        at_neg(); chk("waw_iss5_stall", 64'(bus.dec_stall), 64'h1);
        tick(); idle();
        at_neg(); chk("waw_busy_once", 64'(bus.busy_vec), 64'h20);
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd5; bus.mdu_data = 32'h55;
        push_wr(5'd5, 32'h55);
        tick(); idle();
        tick();
        at_neg(); chk("waw_busy_clear", 64'(bus.busy_vec), 64'h0);

        // Pipeline write to r0 passes through
        tick(); bus.wb_valid = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'hABCD;
        push_wr(5'd0, 32'hABCD);
        at_neg(); chk("wb0_we", 64'(bus.sinal_escrita), 64'h1);

        // Reset with a result still buffered
        tick(); idle(); bus.iss_valid = 1'b1; bus.iss_reg = 5'd8;
        tick(); idle();
        bus.mdu_valid = 1'b1; bus.mdu_reg = 5'd8; bus.mdu_data = 32'h88;
        bus.wb_valid  = 1'b1; bus.wb_reg  = 5'd2; bus.wb_data  = 32'h22;
        push_wr(5'd2, 32'h22);
        tick(); idle(); reset = 1'b1;
        tick(); tick(); reset = 1'b0;
        at_neg();
        chk("midrst_busy",  64'(bus.busy_vec), 64'h0);
        chk("midrst_we",    64'(bus.sinal_escrita), 64'h0);
        chk("midrst_ready", 64'(bus.mdu_ready), 64'h1);

        tick(); tick(); tick();
        at_neg(); chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
